tl_sram_slave: RTL and testbench

Parametrised TileLink-UL slave that fronts a synchronous single-port SRAM model for MMIO/peripheral regions. It is the generalised successor of the fixed 64-bit/128-entry MMIO RAM and supports:
- configurable data width, depth, base address and source-ID width;
- pipelined back-to-back requests;
- an in-order response FIFO that absorbs D-channel back-pressure;
- correct TileLink response opcodes;
- denied responses for out-of-range, misaligned or unsupported requests.

It sits on the L2-to-L3 peripheral crossbar port.

---
 rtl/tl_sram_pkg.sv | 33 +++
 rtl/tl_sram_resp_fifo.sv | 63 ++++++
 rtl/tl_sram_slave.sv | 156 +++++++++++++++
 tb/tb_tl_sram_slave.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_sram_pkg.sv
// Shared TileLink-UL constants, response header layout and sizing helper
// for the SRAM-backed peripheral slave.
package tl_sram_pkg;

    localparam logic [3:0] PUT_FULL        = 4'd0;
    localparam logic [3:0] PUT_PARTIAL     = 4'd1;
    localparam logic [3:0] GET             = 4'd4;
    localparam logic [3:0] ACCESS_ACK      = 4'd0;
    localparam logic [3:0] ACCESS_ACK_DATA = 4'd1;

    // Fixed-width part of a queued response; source and data are appended
    // by the slave because their widths are parameters.
    typedef struct packed {
        logic       has_data;
        logic [2:0] size;
        logic       denied;
        logic       corrupt;
    } resp_hdr_t;

    localparam int RESP_HDR_W = $bits(resp_hdr_t);

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/tl_sram_resp_fifo.sv
// In-order response queue between the SRAM stage and the TileLink D channel.
// The head entry is presented combinationally so D outputs hold while stalled.
module tl_sram_resp_fifo
    import tl_sram_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              pop_data,
    output logic [clog2(DEPTH+1)-1:0]     count,
    output logic                          full,
    output logic                          empty
);

    localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int CNT_W = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_reg == CNT_W'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/tl_sram_slave.sv
// TileLink-UL slave over a single-port synchronous SRAM: one-cycle access
// stage followed by an in-order response FIFO that absorbs D back-pressure.
module tl_sram_slave
    import tl_sram_pkg::*;
#(
    parameter int                DATA_W     = 64,
    parameter int                ADDR_W     = 48,
    parameter int                SRC_W      = 3,
    parameter int                DEPTH      = 128,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                RESP_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [3:0]          a_opcode,
    input  logic [2:0]          a_param,
    input  logic [2:0]          a_size,
    input  logic [SRC_W-1:0]    a_source,
    input  logic [ADDR_W-1:0]   a_address,
    input  logic [DATA_W/8-1:0] a_mask,
    input  logic [DATA_W-1:0]   a_data,
    input  logic                a_corrupt,
    input  logic                d_ready,
    output logic                d_valid,
    output logic [3:0]          d_opcode,
    output logic [1:0]          d_param,
    output logic [2:0]          d_size,
    output logic [SRC_W-1:0]    d_source,
    output logic                d_sink,
    output logic                d_denied,
    output logic [DATA_W-1:0]   d_data,
    output logic                d_corrupt
);

    localparam int               BYTES       = DATA_W / 8;
    localparam int               OFF_W       = clog2(BYTES);
    localparam int               IDX_W       = clog2(DEPTH);
    localparam int               CNT_W       = clog2(RESP_DEPTH + 1);
    localparam int               ENTRY_W     = RESP_HDR_W + SRC_W + DATA_W;
    localparam logic [ADDR_W:0]  REGION_SIZE = (ADDR_W + 1)'(DEPTH * BYTES);

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [DATA_W-1:0]  rd_data_reg;

    logic [ADDR_W:0]    offset;
    logic [IDX_W-1:0]   idx;
    logic [OFF_W-1:0]   align_mask;
    logic               hit, size_ok, aligned, op_put, op_get, legal;
    logic               accept, wr_en, rd_en;
    logic [BYTES-1:0]   lane_we;
    resp_hdr_t          hdr_next;

    logic               s1_valid_reg;
    resp_hdr_t          s1_hdr_reg;
    logic [SRC_W-1:0]   s1_source_reg;
    logic               s1_rd_en_reg;

    logic [ENTRY_W-1:0] push_entry, head_entry;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full, fifo_empty;
    resp_hdr_t          head_hdr;
    logic [SRC_W-1:0]   head_source;
    logic [DATA_W-1:0]  head_data;

    logic               unused_inputs;
    assign unused_inputs = ^{a_param, a_corrupt, fifo_full};

    // Borrow from the subtraction makes below-base addresses compare huge.
    assign offset     = {1'b0, a_address} - {1'b0, BASE_ADDR};
    assign idx        = offset[OFF_W +: IDX_W];
    assign hit        = offset < REGION_SIZE;
    assign size_ok    = a_size <= 3'(OFF_W);
    assign align_mask = ~({OFF_W{1'b1}} << a_size);
    assign aligned    = (a_address[OFF_W-1:0] & align_mask) == '0;
    assign op_put     = (a_opcode == PUT_FULL) || (a_opcode == PUT_PARTIAL);
    assign op_get     = (a_opcode == GET);
    assign legal      = hit && (op_put || op_get) && size_ok && aligned;

    // Only registered state feeds a_ready, so a pop frees a slot one cycle later.
    assign a_ready = (32'(fifo_count) + 32'(s1_valid_reg)) < RESP_DEPTH;
    assign accept  = a_valid && a_ready;
    assign wr_en   = accept && legal && op_put;
    assign rd_en   = accept && legal && op_get;

    always_comb begin
        hdr_next          = '0;
        hdr_next.has_data = op_get;
        hdr_next.size     = a_size;
        hdr_next.denied   = !legal;
        hdr_next.corrupt  = op_get && !legal;
    end

    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
        assign lane_we[gi] = wr_en && a_mask[gi];
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < BYTES; b++) begin
            if (lane_we[b]) begin
                mem[idx][b*8 +: 8] <= a_data[b*8 +: 8];
            end
        end
        if (rd_en) begin
            rd_data_reg <= mem[idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg  <= 1'b0;
            s1_hdr_reg    <= '0;
            s1_source_reg <= '0;
            s1_rd_en_reg  <= 1'b0;
        end else begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_hdr_reg    <= hdr_next;
                s1_source_reg <= a_source;
                s1_rd_en_reg  <= rd_en;
            end
        end
    end

    assign push_entry = {s1_hdr_reg, s1_source_reg, s1_rd_en_reg ? rd_data_reg : {DATA_W{1'b0}}};

    tl_sram_resp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (s1_valid_reg),
        .push_data (push_entry),
        .pop       (d_valid && d_ready),
        .pop_data  (head_entry),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign {head_hdr, head_source, head_data} = head_entry;

    // Storage behind an empty FIFO is undefined, so every field is gated.
    assign d_valid   = !fifo_empty;
    assign d_opcode  = (d_valid && head_hdr.has_data) ? ACCESS_ACK_DATA : ACCESS_ACK;
    assign d_param   = 2'b00;
    assign d_size    = d_valid ? head_hdr.size : 3'd0;
    assign d_source  = d_valid ? head_source : '0;
    assign d_sink    = 1'b0;
    assign d_denied  = d_valid && head_hdr.denied;
    assign d_data    = d_valid ? head_data : '0;
    assign d_corrupt = d_valid && head_hdr.corrupt;

endmodule

// File: tb/tb_tl_sram_slave.sv
// Directed bench: one slave with a 2-entry response FIFO, one with 4 entries,
// sharing the A channel; sel chooses which one is driven and observed.
module tb_tl_sram_slave;

    localparam logic [3:0] OP_PUT_FULL    = 4'd0;
    localparam logic [3:0] OP_PUT_PARTIAL = 4'd1;
    localparam logic [3:0] OP_GET         = 4'd4;
    localparam logic [63:0] PAT           = 64'h0123_4567_89AB_CD00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        a_valid = 1'b0;
    logic        d_ready = 1'b0;
    logic [3:0]  a_opcode = '0;
    logic [2:0]  a_param = '0;
    logic [2:0]  a_size = '0;
    logic [2:0]  a_source = '0;
    logic [47:0] a_address = '0;
    logic [7:0]  a_mask = '0;
    logic [63:0] a_data = '0;
    logic        a_corrupt = 1'b0;

    logic        a_ready2, d_valid2, d_sink2, d_denied2, d_corrupt2;
    logic [3:0]  d_opcode2;
    logic [1:0]  d_param2;
    logic [2:0]  d_size2, d_source2;
    logic [63:0] d_data2;
    logic        a_ready4, d_valid4, d_sink4, d_denied4, d_corrupt4;
    logic [3:0]  d_opcode4;
    logic [1:0]  d_param4;
    logic [2:0]  d_size4, d_source4;
    logic [63:0] d_data4;

    logic        obs_a_ready, obs_valid, obs_sink, obs_denied, obs_corrupt;
    logic [3:0]  obs_opcode;
    logic [1:0]  obs_param;
    logic [2:0]  obs_size, obs_source;
    logic [63:0] obs_data;

    int tests = 0;
    int fails = 0;
    int accepts;

    always #5 clk = ~clk;

    tl_sram_slave #(.RESP_DEPTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .a_valid(a_valid && !sel), .a_ready(a_ready2),
        .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size), .a_source(a_source),
        .a_address(a_address), .a_mask(a_mask), .a_data(a_data), .a_corrupt(a_corrupt),
        .d_ready(d_ready && !sel), .d_valid(d_valid2), .d_opcode(d_opcode2), .d_param(d_param2),
        .d_size(d_size2), .d_source(d_source2), .d_sink(d_sink2), .d_denied(d_denied2),
        .d_data(d_data2), .d_corrupt(d_corrupt2)
    );

    tl_sram_slave #(.RESP_DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .a_valid(a_valid && sel), .a_ready(a_ready4),
        .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size), .a_source(a_source),
        .a_address(a_address), .a_mask(a_mask), .a_data(a_data), .a_corrupt(a_corrupt),
        .d_ready(d_ready && sel), .d_valid(d_valid4), .d_opcode(d_opcode4), .d_param(d_param4),
        .d_size(d_size4), .d_source(d_source4), .d_sink(d_sink4), .d_denied(d_denied4),
        .d_data(d_data4), .d_corrupt(d_corrupt4)
    );

    assign obs_a_ready = sel ? a_ready4   : a_ready2;
    assign obs_valid   = sel ? d_valid4   : d_valid2;
    assign obs_opcode  = sel ? d_opcode4  : d_opcode2;
    assign obs_param   = sel ? d_param4   : d_param2;
    assign obs_size    = sel ? d_size4    : d_size2;
    assign obs_source  = sel ? d_source4  : d_source2;
    assign obs_sink    = sel ? d_sink4    : d_sink2;
    assign obs_denied  = sel ? d_denied4  : d_denied2;
    assign obs_data    = sel ? d_data4    : d_data2;
    assign obs_corrupt = sel ? d_corrupt4 : d_corrupt2;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic expect_now(input string tag, input logic [3:0] opc, input logic [2:0] src,
                              input logic [2:0] size, input logic den, input logic cor,
                              input logic [63:0] data);
        check({tag, ".valid"},   64'(obs_valid), 64'd1);
        check({tag, ".opcode"},  64'(obs_opcode), 64'(opc));
        check({tag, ".source"},  64'(obs_source), 64'(src));
        check({tag, ".size"},    64'(obs_size), 64'(size));
        check({tag, ".denied"},  64'(obs_denied), 64'(den));
        check({tag, ".corrupt"}, 64'(obs_corrupt), 64'(cor));
        check({tag, ".data"},    obs_data, data);
        check({tag, ".psink"},   64'({obs_param, obs_sink}), 64'd0);
        $display("[TB] %s: opcode=%0d source=%0d denied=%0b data=%h", tag, obs_opcode, obs_source, obs_denied, obs_data);
    endtask

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send(input logic [3:0] opc, input logic [2:0] size, input logic [2:0] src,
                        input logic [47:0] addr, input logic [7:0] mask, input logic [63:0] data);
        int n;
        n = 0;
        a_valid = 1'b1; a_opcode = opc; a_size = size; a_source = src;
        a_address = addr; a_mask = mask; a_data = data;
        while (!obs_a_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("send.a_ready", 64'(obs_a_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    task automatic expect_resp(input string tag, input logic [3:0] opc, input logic [2:0] src,
                               input logic [2:0] size, input logic den, input logic cor,
                               input logic [63:0] data);
        int n;
        n = 0;
        while (!obs_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        expect_now(tag, opc, src, size, den, cor, data);
        d_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst.d_valid", 64'(obs_valid), 64'd0);
        check("rst.d_fields", 64'({obs_opcode, obs_size, obs_source, obs_denied, obs_corrupt}), 64'd0);
        check("rst.d_data", obs_data, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.a_ready", 64'(obs_a_ready), 64'd1);

        // Full write then read of the same word on consecutive cycles
        send(OP_PUT_FULL, 3'd3, 3'd2, 48'h08, 8'hFF, 64'h1122_3344_5566_7788);
        send(OP_GET,      3'd3, 3'd5, 48'h08, 8'hFF, 64'd0);
        expect_resp("put08", 4'd0, 3'd2, 3'd3, 1'b0, 1'b0, 64'd0);
        expect_resp("get08", 4'd1, 3'd5, 3'd3, 1'b0, 1'b0, 64'h1122_3344_5566_7788);

        // Partial write over a zeroed word
        send(OP_PUT_FULL, 3'd3, 3'd0, 48'h10, 8'hFF, 64'd0);
        expect_resp("zero10", 4'd0, 3'd0, 3'd3, 1'b0, 1'b0, 64'd0);
        send(OP_PUT_PARTIAL, 3'd3, 3'd1, 48'h10, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF);
        send(OP_GET,         3'd3, 3'd6, 48'h10, 8'hFF, 64'd0);
        expect_resp("ppart10", 4'd0, 3'd1, 3'd3, 1'b0, 1'b0, 64'd0);
        expect_resp("get10",   4'd1, 3'd6, 3'd3, 1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF);

        // Out-of-range, unsupported opcode: denied, no SRAM access
        send(OP_PUT_FULL, 3'd3, 3'd7, 48'h00, 8'hFF, 64'hDEAD_BEEF_0BAD_F00D);
        expect_resp("put00", 4'd0, 3'd7, 3'd3, 1'b0, 1'b0, 64'd0);
        send(OP_GET, 3'd3, 3'd1, 48'h400, 8'hFF, 64'd0);
        expect_resp("get400", 4'd1, 3'd1, 3'd3, 1'b1, 1'b1, 64'd0);
        send(OP_PUT_FULL, 3'd3, 3'd2, 48'h400, 8'hFF, 64'h5555_5555_5555_5555);
        expect_resp("put400", 4'd0, 3'd2, 3'd3, 1'b1, 1'b0, 64'd0);
        send(4'd6, 3'd3, 3'd3, 48'h08, 8'hFF, 64'd0);
        expect_resp("op6", 4'd0, 3'd3, 3'd3, 1'b1, 1'b0, 64'd0);
        send(OP_GET, 3'd3, 3'd4, 48'h00, 8'hFF, 64'd0);
        expect_resp("get00", 4'd1, 3'd4, 3'd3, 1'b0, 1'b0, 64'hDEAD_BEEF_0BAD_F00D);

        // Alignment and size limits
        send(OP_GET, 3'd3, 3'd0, 48'h04, 8'hFF, 64'd0);
        expect_resp("misalign", 4'd1, 3'd0, 3'd3, 1'b1, 1'b1, 64'd0);
        send(OP_GET, 3'd2, 3'd1, 48'h04, 8'hF0, 64'd0);
        expect_resp("get04w", 4'd1, 3'd1, 3'd2, 1'b0, 1'b0, 64'hDEAD_BEEF_0BAD_F00D);
        send(OP_GET, 3'd4, 3'd2, 48'h00, 8'hFF, 64'd0);
        expect_resp("oversize", 4'd1, 3'd2, 3'd4, 1'b1, 1'b1, 64'd0);

        // Corrupt Put still writes and is acknowledged normally
        a_corrupt = 1'b1;
        send(OP_PUT_PARTIAL, 3'd3, 3'd5, 48'h00, 8'hF0, 64'hAAAA_AAAA_0000_0000);
        a_corrupt = 1'b0;
        expect_resp("putcorr", 4'd0, 3'd5, 3'd3, 1'b0, 1'b0, 64'd0);
        send(OP_GET, 3'd3, 3'd6, 48'h00, 8'hFF, 64'd0);
        expect_resp("getcorr", 4'd1, 3'd6, 3'd3, 1'b0, 1'b0, 64'hAAAA_AAAA_0BAD_F00D);

        // Back-pressure with a 2-entry FIFO
        accepts = 0;
        a_valid = 1'b1; a_opcode = OP_GET; a_size = 3'd3; a_mask = 8'hFF; a_data = '0;
        for (int c = 0; c < 6; c++) begin
            a_source  = 3'(3 + accepts);
            a_address = (accepts == 0) ? 48'h08 : 48'h10;
            if (obs_a_ready) accepts++;
            @(posedge clk);
            @(negedge clk);
        end
        a_valid = 1'b0;
        check("bp.accepts", 64'(accepts), 64'd2);
        check("bp.a_ready", 64'(obs_a_ready), 64'd0);
        expect_now("bp.hold0", 4'd1, 3'd3, 3'd3, 1'b0, 1'b0, 64'h1122_3344_5566_7788);
        @(negedge clk);
        expect_now("bp.hold1", 4'd1, 3'd3, 3'd3, 1'b0, 1'b0, 64'h1122_3344_5566_7788);
        expect_resp("bp.r0", 4'd1, 3'd3, 3'd3, 1'b0, 1'b0, 64'h1122_3344_5566_7788);
        expect_resp("bp.r1", 4'd1, 3'd4, 3'd3, 1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF);
        @(negedge clk);
        check("bp.drained", 64'(obs_valid), 64'd0);

        // Full-rate stream into the 4-entry FIFO: 8 writes then 8 reads
        sel = 1'b1;
        d_ready = 1'b1;
        @(negedge clk);
        for (int j = 0; j < 18; j++) begin
            if (j >= 2) begin
                if (j - 2 < 8)
                    expect_now($sformatf("str.w%0d", j - 2), 4'd0, 3'(j - 2), 3'd3, 1'b0, 1'b0, 64'd0);
                else
                    expect_now($sformatf("str.r%0d", j - 10), 4'd1, 3'(j - 2), 3'd3, 1'b0, 1'b0, PAT + 64'(j - 10));
            end
            if (j < 16) begin
                check($sformatf("str.a_ready%0d", j), 64'(obs_a_ready), 64'd1);
                a_valid   = 1'b1;
                a_opcode  = (j < 8) ? OP_PUT_FULL : OP_GET;
                a_source  = 3'(j);
                a_address = 48'h100 + 48'(8 * (j % 8));
                a_data    = PAT + 64'(j);
                a_mask    = 8'hFF;
            end else begin
                a_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        a_valid = 1'b0;
        d_ready = 1'b0;
        check("str.drained", 64'(obs_valid), 64'd0);

        // Reset with responses queued: queue flushed, SRAM retained
        send(OP_GET, 3'd3, 3'd1, 48'h108, 8'hFF, 64'd0);
        send(OP_GET, 3'd3, 3'd2, 48'h110, 8'hFF, 64'd0);
        check("mid.d_valid", 64'(obs_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1 check("mid.async", 64'(obs_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("mid.flushed", 64'(obs_valid), 64'd0);
        send(OP_GET, 3'd3, 3'd5, 48'h108, 8'hFF, 64'd0);
        expect_resp("mid.get108", 4'd1, 3'd5, 3'd3, 1'b0, 1'b0, PAT + 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
